led_demux_sequencer: RTL

LED_DEMUX_SEQUENCER -- requirements
Module: led_demux_sequencer

---
 rtl/led_demux_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/led_demux_sequencer.sv
// LED demux sequencer: walks a registered 3-bit select across eight LEDs,
// dwelling a programmable number of clocks per position, in four sweep modes.
module led_demux_sequencer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] dwell,
  input  logic             x_in,
  output logic [2:0]       sel,
  output logic             x_out,
  output logic [7:0]       LED,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_WRAP   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  state_t           state_q, state_d;
  logic [2:0]       sel_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;   // 1 = stepping down
  logic             done_d;
  logic             finish;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d = state_q;
    sel_d   = sel;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        cnt_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          dwell_d = (dwell == '0) ? DIV_W'(1) : dwell;
          sel_d   = (mode == MODE_DOWN) ? 3'd7 : 3'd0;
          dir_d   = (mode == MODE_DOWN);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end else if (cnt_q == dwell_q - DIV_W'(1)) begin
          cnt_d = '0;
          case (mode_q)
            MODE_UP:   if (sel == 3'd7) finish = 1'b1; else sel_d = sel + 3'd1;
            MODE_DOWN: if (sel == 3'd0) finish = 1'b1; else sel_d = sel - 3'd1;
            MODE_WRAP: sel_d = sel + 3'd1;
            MODE_BOUNCE: begin
              // Turn around at an endpoint only after it has had its dwell.
              if (!dir_q) begin
                if (sel == 3'd7) begin
                  sel_d = 3'd6;
                  dir_d = 1'b1;
                end else begin
                  sel_d = sel + 3'd1;
                end
              end else begin
                if (sel == 3'd0) begin
                  sel_d = 3'd1;
                  dir_d = 1'b0;
                end else begin
                  sel_d = sel - 3'd1;
                end
              end
            end
            default: sel_d = sel;
          endcase
          if (finish) begin
            state_d = IDLE;
            sel_d   = 3'd0;
            dir_d   = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel     <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= DIV_W'(1);
      mode_q  <= MODE_UP;
      dir_q   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      done    <= done_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign x_out = busy & x_in;

  always_comb begin
    LED = x_out ? (8'b1 << sel) : 8'h00;
  end

endmodule
